// File: rtl/mem_pkt_tx.sv
// mem_pkt_tx: sends a block of words read from data memory port B as one
// packet on the datastream.
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   start/base_addr/word_count/eop_ctrl : transfer request from software
//   mem_addr/mem_rd_en/mem_dout         : memory read port (one-cycle latency)
//   out_data/out_ctrl/out_wr/out_rdy    : datastream output
//   busy/done/err/pkt_count             : status back to software
module mem_pkt_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 8,
    parameter logic [CTRL_WIDTH-1:0] HDR_CTRL = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic [CTRL_WIDTH-1:0] eop_ctrl,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           pkt_count
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] TWO = 2;

    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0] addr_reg;      // next read address
    logic [ADDR_WIDTH-1:0] count_reg;
    logic [CTRL_WIDTH-1:0] eop_reg;
    logic [ADDR_WIDTH-1:0] rd_cnt_reg;    // reads issued
    logic [ADDR_WIDTH-1:0] cap_cnt_reg;   // words captured from memory
    logic [ADDR_WIDTH-1:0] emit_cnt_reg;  // words written to the stream
    logic                  pend_reg;      // read issued last cycle, data on mem_dout now

    logic [DATA_WIDTH-1:0] buf_data_reg [2];
    logic [CTRL_WIDTH-1:0] buf_ctrl_reg [2];
    logic                  head_reg, tail_reg;
    logic [1:0]            occ_reg;

    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [CTRL_WIDTH-1:0] out_ctrl_reg;
    logic                  out_wr_reg, done_reg, err_reg;
    logic [31:0]           pkt_count_reg;

    logic                  accept, reject, rd_issue;
    logic                  pop, bypass, push, emit, last_emit;
    logic [CTRL_WIDTH-1:0] cap_ctrl;

    always_comb begin
        accept = (state_reg == IDLE) && start && (word_count >= TWO);
        reject = (state_reg == IDLE) && start && (word_count < TWO);
        // Occupancy plus the read already in flight must leave room for one more.
        rd_issue = (state_reg == RUN) && (rd_cnt_reg != count_reg)
                   && ((occ_reg + {1'b0, pend_reg}) < 2'd2);
        // Tag is decided when the word is captured and travels with it.
        if (cap_cnt_reg == '0)
            cap_ctrl = HDR_CTRL;
        else if (cap_cnt_reg == count_reg - ONE)
            cap_ctrl = eop_reg;
        else
            cap_ctrl = '0;
        pop       = out_rdy && (occ_reg != 2'd0);
        // Empty buffer: returning data goes straight to the output register.
        bypass    = out_rdy && (occ_reg == 2'd0) && pend_reg;
        push      = pend_reg && !bypass;
        emit      = pop || bypass;
        last_emit = emit && (emit_cnt_reg == count_reg - ONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (done_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg      <= '0;
            count_reg     <= '0;
            eop_reg       <= '0;
            rd_cnt_reg    <= '0;
            cap_cnt_reg   <= '0;
            emit_cnt_reg  <= '0;
            pend_reg      <= 1'b0;
            head_reg      <= 1'b0;
            tail_reg      <= 1'b0;
            occ_reg       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_reg[i] <= '0;
                buf_ctrl_reg[i] <= '0;
            end
            out_data_reg  <= '0;
            out_ctrl_reg  <= '0;
            out_wr_reg    <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            pkt_count_reg <= '0;
        end else begin
            err_reg <= reject;
            if (accept) begin
                addr_reg     <= base_addr;
                count_reg    <= word_count;
                eop_reg      <= eop_ctrl;
                rd_cnt_reg   <= '0;
                cap_cnt_reg  <= '0;
                emit_cnt_reg <= '0;
            end

            pend_reg <= rd_issue;
            if (rd_issue) begin
                addr_reg   <= addr_reg + ONE;
                rd_cnt_reg <= rd_cnt_reg + ONE;
            end
            if (pend_reg)
                cap_cnt_reg <= cap_cnt_reg + ONE;

            if (push) begin
                buf_data_reg[tail_reg] <= mem_dout;
                buf_ctrl_reg[tail_reg] <= cap_ctrl;
                tail_reg <= ~tail_reg;
            end
            if (pop)
                head_reg <= ~head_reg;
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase

            out_wr_reg <= emit;
            if (emit) begin
                out_data_reg <= pop ? buf_data_reg[head_reg] : mem_dout;
                out_ctrl_reg <= pop ? buf_ctrl_reg[head_reg] : cap_ctrl;
                emit_cnt_reg <= emit_cnt_reg + ONE;
            end
            done_reg <= last_emit;
            if (done_reg)
                pkt_count_reg <= pkt_count_reg + 32'd1;
        end
    end

    assign mem_addr  = addr_reg;
    assign mem_rd_en = rd_issue;
    assign out_data  = out_data_reg;
    assign out_ctrl  = out_ctrl_reg;
    assign out_wr    = out_wr_reg;
    assign busy      = (state_reg == RUN);
    assign done      = done_reg;
    assign err       = err_reg;
    assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_mem_pkt_tx.sv
// tb_mem_pkt_tx: directed and randomized transfers against a queue-based
// reference of the expected packet (words, tags, read addresses, counts).
module tb_mem_pkt_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [7:0]  word_count = '0;
    logic [7:0]  eop_ctrl = '0;
    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic [63:0] mem_dout = '0;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;
    logic        busy, done, err;
    logic [31:0] pkt_count;

    mem_pkt_tx dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .eop_ctrl(eop_ctrl), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_dout(mem_dout), .out_data(out_data),
        .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy), .busy(busy),
        .done(done), .err(err), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [256];
    always @(posedge clk) if (mem_rd_en) mem_dout <= mem[mem_addr];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [71:0] exp_q [$];
    logic [7:0]  exp_addr;
    int          rd_issued, emitted, cur_n;
    int          rdy_mode = 0;
    int          pat_idx = 0;
    bit          pat [6] = '{1, 0, 0, 1, 0, 1};
    bit          wr_seen, done_seen;
    int          exp_pkts = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_rdy();
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       begin out_rdy = pat[pat_idx % 6]; pat_idx++; end
            default: out_rdy = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock; observes the cycle that follows the edge.
    task automatic tick();
        bit          pr;
        logic [71:0] e;
        pr = out_rdy;
        @(posedge clk);
        #1;
        cyc++;
        wr_seen = out_wr;
        done_seen = done;
        if (out_wr) begin
            check("wr_after_rdy", pr, 1);
            check("wr_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                emitted++;
                check("data", out_data, e[63:0]);
                check("ctrl", out_ctrl, e[71:64]);
                $display("cyc=%0d word data=%h ctrl=%h done=%0d", cyc, out_data, out_ctrl, done);
            end
        end
        if (out_wr || done) check("done_with_last", done, out_wr && exp_q.size() == 0);
        if (mem_rd_en) begin
            check("rd_addr", mem_addr, exp_addr);
            exp_addr++;
            rd_issued++;
            check("rd_bound", rd_issued <= cur_n, 1);
            check("occupancy", (rd_issued - emitted) <= 2, 1);
        end
        drive_rdy();
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] n, input logic [7:0] e,
                        input int mode, input int inject, input int rst_at);
        int c0, first_wr, last_wr, finished;
        logic [7:0] a;
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            a = b + 8'(i);
            exp_q.push_back({(i == 0) ? 8'hFF : (i == int'(n) - 1) ? e : 8'h00, mem[a]});
        end
        exp_addr = b; rd_issued = 0; emitted = 0; cur_n = int'(n);
        rdy_mode = mode; pat_idx = 0; drive_rdy();
        base_addr = b; word_count = n; eop_ctrl = e; start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        check("busy_after_start", busy, 1);
        first_wr = -1; last_wr = -1; finished = 0;
        for (int k = 0; k < 500 && finished == 0; k++) begin
            if (k == inject) begin
                start = 1'b1; base_addr = 8'h55; word_count = 8'd3; eop_ctrl = 8'h11;
            end
            tick();
            if (k == inject) begin
                start = 1'b0;
                check("err_ignored_in_run", err, 0);
            end
            if (wr_seen) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (done_seen) finished = 1;
            else if (rst_at > 0 && emitted == rst_at) begin
                reset = 1'b0;
                #1;
                check("rst_out_wr", out_wr, 0);
                check("rst_done", done, 0);
                check("rst_busy", busy, 0);
                check("rst_rd_en", mem_rd_en, 0);
                check("rst_pkt_count", pkt_count, 0);
                exp_q.delete();
                exp_pkts = 0;
                cur_n = 0;
                repeat (3) tick();
                reset = 1'b1;
                finished = 2;
            end
        end
        check("completed", finished != 0, 1);
        if (finished == 1) begin
            if (mode == 0) begin
                check("first_wr_latency", first_wr - c0, 2);
                check("no_bubbles", last_wr - first_wr, int'(n) - 1);
            end
            exp_pkts++;
            tick();
            check("busy_after_done", busy, 0);
            check("pkt_count", pkt_count, exp_pkts);
            check("all_words_sent", exp_q.size(), 0);
            $display("packet base=%h n=%0d mode=%0d pkt_count=%0d", b, n, mode, pkt_count);
        end
    endtask

    task automatic reject(input logic [7:0] n);
        exp_q.delete(); cur_n = 0; rd_issued = 0; emitted = 0;
        base_addr = 8'h20; word_count = n; eop_ctrl = 8'h0F; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", err, 1);
        check("busy_on_reject", busy, 0);
        tick();
        check("err_one_cycle", err, 0);
        $display("reject n=%0d err observed", n);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 64'(i + 1);
        #2;
        check("reset_out_wr", out_wr, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_ctrl", out_ctrl, 0);
        check("reset_busy", busy, 0);
        check("reset_pkt_count", pkt_count, 0);
        check("reset_rd_en", mem_rd_en, 0);
        #20;
        reset = 1'b1;
        tick();

        send(8'h10, 8'd4, 8'h80, 0, -1, 0);
        send(8'h10, 8'd4, 8'h80, 1, -1, 0);
        send(8'hFE, 8'd4, 8'h3C, 0, -1, 0);
        reject(8'd0);
        reject(8'd1);
        send(8'h40, 8'd2, 8'h07, 0, -1, 0);
        send(8'h80, 8'd8, 8'hE0, 0, 2, 0);
        send(8'hA0, 8'd6, 8'hC0, 0, -1, 2);
        send(8'hA0, 8'd6, 8'hC0, 1, -1, 0);
        for (int t = 0; t < 10; t++)
            send(8'($urandom_range(0, 255)), 8'($urandom_range(2, 16)),
                 8'($urandom), 2, -1, 0);
        send(8'hF8, 8'd20, 8'hFF, 2, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
